// File: rtl/hamming_code.sv
// Registered Hamming(7,4) encoder plus independent syndrome decoder, one result per clock.
// Define HAMMING_CORRECT_EN to apply single-bit correction to data_out; otherwise detect only.
module hamming_code (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] data_in,
  output logic [6:0] code_out,
  input  logic [6:0] code_in,
  output logic [3:0] data_out,
  output logic [2:0] syndrome,
  output logic       error
);

  // Codeword layout, LSB first: p1 p2 d1 p3 d2 d3 d4 (even parity).
  function automatic logic [6:0] hamming_encode(input logic [3:0] d);
    hamming_encode = {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3],
                      d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
  endfunction

  function automatic logic [2:0] hamming_syndrome(input logic [6:0] c);
    hamming_syndrome = {c[3] ^ c[4] ^ c[5] ^ c[6],
                        c[1] ^ c[2] ^ c[5] ^ c[6],
                        c[0] ^ c[2] ^ c[4] ^ c[6]};
  endfunction

  function automatic logic [3:0] hamming_extract(input logic [6:0] c);
    hamming_extract = {c[6], c[5], c[4], c[2]};
  endfunction

`ifdef HAMMING_CORRECT_EN
  // Syndrome value is the 1-based position of the bit to invert.
  function automatic logic [6:0] hamming_flip_mask(input logic [2:0] s);
    case (s)
      3'd1:    hamming_flip_mask = 7'b0000001;
      3'd2:    hamming_flip_mask = 7'b0000010;
      3'd3:    hamming_flip_mask = 7'b0000100;
      3'd4:    hamming_flip_mask = 7'b0001000;
      3'd5:    hamming_flip_mask = 7'b0010000;
      3'd6:    hamming_flip_mask = 7'b0100000;
      3'd7:    hamming_flip_mask = 7'b1000000;
      default: hamming_flip_mask = 7'b0000000;
    endcase
  endfunction
`endif

  logic [6:0] code_next_s;
  logic [2:0] syndrome_s;
  logic [6:0] fixed_code_s;
  logic [3:0] data_next_s;

  // Next-state values for both independent paths.
  always_comb begin
    code_next_s  = hamming_encode(data_in);
    syndrome_s   = hamming_syndrome(code_in);
`ifdef HAMMING_CORRECT_EN
    fixed_code_s = code_in ^ hamming_flip_mask(syndrome_s);
`else
    fixed_code_s = code_in;
`endif
    data_next_s  = hamming_extract(fixed_code_s);
  end

  // Output registers; asynchronous reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_out <= 7'b0000000;
      data_out <= 4'b0000;
      syndrome <= 3'b000;
      error    <= 1'b0;
    end else begin
      code_out <= code_next_s;
      data_out <= data_next_s;
      syndrome <= syndrome_s;
      error    <= (syndrome_s != 3'b000);
    end
  end

endmodule

// File: tb/tb_hamming_code.sv
// Scoreboard bench for hamming_code: stimulus pushes expected results, a monitor pops them
// one cycle later. Honours HAMMING_CORRECT_EN for the expected decoded data.
module tb_hamming_code;

  typedef struct packed {
    logic [6:0] code;
    logic [3:0] data;
    logic [2:0] syn;
    logic       err;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] data_in;
  logic [6:0] code_out;
  logic [6:0] code_in;
  logic [3:0] data_out;
  logic [2:0] syndrome;
  logic       error;

  logic       in_valid;
  exp_t       exp_q[$];
  int         n_cmp;
  int         n_bad;

  // Hand-computed codewords for nibbles 0..15.
  logic [6:0] code_tbl [16] = '{
    7'b0000000, 7'b0000111, 7'b0011001, 7'b0011110,
    7'b0101010, 7'b0101101, 7'b0110011, 7'b0110100,
    7'b1001011, 7'b1001100, 7'b1010010, 7'b1010101,
    7'b1100001, 7'b1100110, 7'b1111000, 7'b1111111
  };

  hamming_code dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .code_out (code_out),
    .code_in  (code_in),
    .data_out (data_out),
    .syndrome (syndrome),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " code_out"}, code_out, 7'b0000000);
    chk({tag, " data_out"}, {3'b000, data_out}, 7'b0000000);
    chk({tag, " syndrome"}, {4'b0000, syndrome}, 7'b0000000);
    chk({tag, " error"}, {6'b000000, error}, 7'b0000000);
  endtask

  task automatic apply(input logic [3:0] d, input logic [6:0] c, input logic [6:0] e_code,
                       input logic [3:0] e_data, input logic [2:0] e_syn, input logic e_err);
    exp_t e;
    @(negedge clk);
    data_in  = d;
    code_in  = c;
    in_valid = 1'b1;
    e.code = e_code;
    e.data = e_data;
    e.syn  = e_syn;
    e.err  = e_err;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Monitor: a vector sampled at an edge is checked just after that edge.
  initial begin
    logic cap;
    exp_t e;
    forever begin
      @(posedge clk);
      cap = in_valid;
      #2;
      if (cap && rst_n) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL scoreboard: output with empty queue at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("code_out", code_out, e.code);
          chk("data_out", {3'b000, data_out}, {3'b000, e.data});
          chk("syndrome", {4'b0000, syndrome}, {4'b0000, e.syn});
          chk("error", {6'b000000, error}, {6'b000000, e.err});
        end
      end
    end
  end

  initial begin
    logic [6:0] c;
    logic [3:0] exp_d;
    n_cmp    = 0;
    n_bad    = 0;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    data_in  = 4'b1011;
    code_in  = 7'b1010101;
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    apply(4'b0000, 7'b0000000, 7'b0000000, 4'b0000, 3'd0, 1'b0);
    apply(4'b0001, 7'b1001011, 7'b0000111, 4'b1000, 3'd0, 1'b0);
    apply(4'b0010, 7'b1001011, 7'b0011001, 4'b1000, 3'd0, 1'b0);
    apply(4'b0100, 7'b1001011, 7'b0101010, 4'b1000, 3'd0, 1'b0);
    apply(4'b1000, 7'b1001011, 7'b1001011, 4'b1000, 3'd0, 1'b0);
    apply(4'b1111, 7'b1001011, 7'b1111111, 4'b1000, 3'd0, 1'b0);
`ifdef HAMMING_CORRECT_EN
    apply(4'b0000, 7'b0000011, 7'b0000000, 4'b0001, 3'd3, 1'b1);
`else
    apply(4'b0000, 7'b0000011, 7'b0000000, 4'b0000, 3'd3, 1'b1);
`endif

    for (int n = 0; n < 16; n++) begin
      for (int k = 1; k <= 7; k++) begin
        c = code_tbl[n] ^ (7'b0000001 << (k - 1));
`ifdef HAMMING_CORRECT_EN
        exp_d = n[3:0];
`else
        exp_d = {c[6], c[5], c[4], c[2]};
`endif
        apply(n[3:0], c, code_tbl[n], exp_d, k[2:0], 1'b1);
      end
    end

    // Asynchronous reset pulse between edges, then resume streaming.
    apply(4'b1111, 7'b1111111, 7'b1111111, 4'b1111, 3'd0, 1'b0);
    idle();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_zero("async reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("hold after release");
    in_valid = 1'b0;
    apply(4'b0101, 7'b0101101, 7'b0101101, 4'b0101, 3'd0, 1'b0);
    apply(4'b1010, 7'b1010010, 7'b1010010, 4'b1010, 3'd0, 1'b0);
    idle();

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #3;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
